lfsr_checker: RTL and testbench

Receive-side companion to the 16-bit LFSR generator: consumes the generator's serial output bit stream, self-synchronises a local copy of the LFSR, then predicts each following bit and counts mismatches. On loss of lock it writes the accumulated error count into the shared memory as a single write, then re-acquires. It sits between any path carrying generator bits (loopback, link, test harness) and the `mem` block.

---
 rtl/lfsr_pkg.sv | 31 +++
 rtl/lfsr_checker_if.sv | 37 +++
 rtl/lfsr_checker.sv | 198 +++++++++++++++++++
 tb/tb_lfsr_checker.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// ----------------------------------------------------------------------------
// lfsr_pkg
// Definitions shared by the 16-bit LFSR generator and lfsr_checker:
//   - feedback tap positions and the fb() feedback function (XNOR form)
//   - the XNOR lockup state (all ones)
//   - the checker state enumeration
//   - the default memory word that receives the checker's error report
// ----------------------------------------------------------------------------
package lfsr_pkg;

    localparam int unsigned TAP_A = 15;
    localparam int unsigned TAP_B = 14;
    localparam int unsigned TAP_C = 12;
    localparam int unsigned TAP_D = 3;

    // An XNOR LFSR sitting at all ones feeds back a one forever.
    localparam logic [15:0] LFSR_LOCKUP = 16'hFFFF;

    localparam logic [15:0] REPORT_ADDR_DEFAULT = 16'h07FD;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        CHECK  = 2'd1,
        REPORT = 2'd2
    } chk_state_t;

    function automatic logic fb(input logic [15:0] r);
        return ~(r[TAP_A] ^ r[TAP_B] ^ r[TAP_C] ^ r[TAP_D]);
    endfunction

endpackage

// File: rtl/lfsr_checker_if.sv
// ----------------------------------------------------------------------------
// lfsr_checker_if
// Groups the checker's serial bit input and its memory write bus.
//   in_valid     : in_bit is meaningful this cycle
//   in_bit       : received generator bit (generator's shift-in bit)
//   mem_wr_en    : single-cycle memory write strobe
//   mem_address  : memory word address (constant report address)
//   mem_data     : memory write data (holds last written value)
// Modports:
//   master : the bit source / memory side
//   slave  : the checker
// ----------------------------------------------------------------------------
interface lfsr_checker_if;

    logic        in_valid;
    logic        in_bit;
    logic        mem_wr_en;
    logic [15:0] mem_address;
    logic [15:0] mem_data;

    modport master (
        output in_valid,
        output in_bit,
        input  mem_wr_en,
        input  mem_address,
        input  mem_data
    );

    modport slave (
        input  in_valid,
        input  in_bit,
        output mem_wr_en,
        output mem_address,
        output mem_data
    );

endinterface

// File: rtl/lfsr_checker.sv
// ----------------------------------------------------------------------------
// lfsr_checker
// Receive-side checker for the 16-bit XNOR LFSR generator. Loads 16 received
// bits into a local LFSR copy, then predicts every following bit and counts
// mismatches. Too many mismatches inside one evaluation window drop lock; the
// running error count is then written to memory once and the checker reloads.
//
// Ports:
//   clock        : sole clock, rising edge
//   reset        : asynchronous, active-high
//   bus          : lfsr_checker_if.slave (in_valid/in_bit, mem_* write bus)
//   clear_counts : synchronous pulse zeroing err_count and bit_count
//   locked       : high while checking
//   err_count    : saturating mismatch count since reset/clear
//   bit_count    : saturating count of checked bits since reset/clear
// ----------------------------------------------------------------------------
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int unsigned LOCK_WINDOW = 64,
    parameter int unsigned ERR_THRESH  = 4,
    parameter logic [15:0] REPORT_ADDR = REPORT_ADDR_DEFAULT
) (
    input  logic                 clock,
    input  logic                 reset,
    lfsr_checker_if.slave        bus,
    input  logic                 clear_counts,
    output logic                 locked,
    output logic [15:0]          err_count,
    output logic [15:0]          bit_count
);

    localparam logic [15:0] WIN_LEN = 16'(LOCK_WINDOW);
    localparam logic [15:0] THRESH  = 16'(ERR_THRESH);

    chk_state_t  state_q, state_d;
    logic [15:0] r_q, r_d;
    logic [3:0]  fill_q, fill_d;
    logic [15:0] werr_q, werr_d;
    logic [15:0] wbit_q, wbit_d;
    logic [15:0] err_q, err_d;
    logic [15:0] bits_q, bits_d;
    logic [15:0] data_q, data_d;

    logic        exp_bit;
    logic [15:0] load_r;
    logic        chk_bit;
    logic        mism;
    logic [15:0] werr_inc;
    logic [15:0] wbit_inc;
    logic        thresh_hit;
    logic        fill_done;
    logic        locked_c;
    logic        wr_en_c;

    // Shared decode of the current bit
    always_comb begin
        exp_bit    = fb(r_q);
        load_r     = {r_q[14:0], bus.in_bit};
        chk_bit    = (state_q == CHECK) && bus.in_valid;
        mism       = chk_bit && (bus.in_bit != exp_bit);
        werr_inc   = werr_q + {15'd0, mism};
        wbit_inc   = wbit_q + 16'd1;
        thresh_hit = chk_bit && (werr_inc >= THRESH);
        fill_done  = (state_q == LOAD) && bus.in_valid && (fill_q == 4'd15);
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LOAD: begin
                // A fill ending in the lockup state can never predict
                // anything but ones, so it is discarded and refilled.
                if (fill_done && (load_r != LFSR_LOCKUP)) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (thresh_hit) begin
                    state_d = REPORT;
                end
            end
            REPORT: begin
                state_d = LOAD;
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    // Output decode, straight from the state register
    always_comb begin
        locked_c = (state_q == CHECK);
        wr_en_c  = (state_q == REPORT);
    end

    // Datapath next values
    always_comb begin
        r_d    = r_q;
        fill_d = fill_q;
        werr_d = werr_q;
        wbit_d = wbit_q;
        err_d  = err_q;
        bits_d = bits_q;
        data_d = data_q;

        unique case (state_q)
            LOAD: begin
                if (bus.in_valid) begin
                    r_d    = load_r;
                    fill_d = fill_done ? 4'd0 : fill_q + 4'd1;
                end
            end
            CHECK: begin
                if (bus.in_valid) begin
                    // Free-running on the prediction; in_bit never enters r.
                    r_d = {r_q[14:0], exp_bit};
                    if (!thresh_hit && (wbit_inc == WIN_LEN)) begin
                        werr_d = '0;
                        wbit_d = '0;
                    end else begin
                        werr_d = werr_inc;
                        wbit_d = wbit_inc;
                    end
                end
            end
            REPORT: begin
                r_d    = '0;
                fill_d = '0;
                werr_d = '0;
                wbit_d = '0;
            end
            default: begin
                r_d    = '0;
                fill_d = '0;
                werr_d = '0;
                wbit_d = '0;
            end
        endcase

        if (chk_bit && (bits_q != 16'hFFFF)) begin
            bits_d = bits_q + 16'd1;
        end
        if (mism && (err_q != 16'hFFFF)) begin
            err_d = err_q + 16'd1;
        end
        if (clear_counts) begin
            err_d  = '0;
            bits_d = '0;
        end

        // Captured on the threshold edge so the write data reflects the
        // count including the threshold bit (and any coincident clear).
        if (thresh_hit) begin
            data_d = err_d;
        end
    end

    // Datapath registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_q    <= '0;
            fill_q <= '0;
            werr_q <= '0;
            wbit_q <= '0;
            err_q  <= '0;
            bits_q <= '0;
            data_q <= '0;
        end else begin
            r_q    <= r_d;
            fill_q <= fill_d;
            werr_q <= werr_d;
            wbit_q <= wbit_d;
            err_q  <= err_d;
            bits_q <= bits_d;
            data_q <= data_d;
        end
    end

    assign locked          = locked_c;
    assign err_count       = err_q;
    assign bit_count       = bits_q;
    assign bus.mem_wr_en   = wr_en_c;
    assign bus.mem_address = REPORT_ADDR;
    assign bus.mem_data    = data_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// ----------------------------------------------------------------------------
// tb_lfsr_checker
// Directed bench for lfsr_checker: clean lock on a seeded generator stream,
// windowed error tolerance, loss-of-lock report, clear_counts priority,
// all-ones lockup rejection and asynchronous reset mid-fill / mid-report.
// ----------------------------------------------------------------------------
module tb_lfsr_checker;

    logic        clock;
    logic        reset;
    logic        clear_counts;
    logic        locked;
    logic [15:0] err_count;
    logic [15:0] bit_count;

    lfsr_checker_if bus ();

    lfsr_checker #(
        .LOCK_WINDOW (64),
        .ERR_THRESH  (4),
        .REPORT_ADDR (16'h07FD)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .bus          (bus.slave),
        .clear_counts (clear_counts),
        .locked       (locked),
        .err_count    (err_count),
        .bit_count    (bit_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int tests;
    int fails;
    int wr_pulses;
    int lock_cycles;

    logic [15:0] g;   // reference generator state

    always @(negedge clock) begin
        if (bus.mem_wr_en === 1'b1) wr_pulses++;
        if (locked === 1'b1) lock_cycles++;
    end

    function automatic logic gen_fb(input logic [15:0] s);
        return ~(s[15] ^ s[14] ^ s[12] ^ s[3]);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic b);
        bus.in_valid = 1'b1;
        bus.in_bit   = b;
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
        bus.in_bit   = 1'b0;
    endtask

    task automatic gen_step(input logic flip);
        logic nb;
        nb = gen_fb(g);
        g  = {g[14:0], nb};
        send(nb ^ flip);
    endtask

    task automatic load_seed(input logic [15:0] s, input string tag);
        g = s;
        for (int i = 15; i >= 1; i--) send(s[i]);
        check({tag, "_unlocked_at_15"}, locked, 1'b0);
        send(s[0]);
        check({tag, "_locked_at_16"}, locked, 1'b1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_locked"},   locked,          1'b0);
        check({tag, "_err"},      err_count,       16'd0);
        check({tag, "_bits"},     bit_count,       16'd0);
        check({tag, "_wr_en"},    bus.mem_wr_en,   1'b0);
        check({tag, "_address"},  bus.mem_address, 16'h07FD);
        check({tag, "_data"},     bus.mem_data,    16'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "simulation exceeded time limit");
    end

    initial begin
        tests        = 0;
        fails        = 0;
        wr_pulses    = 0;
        lock_cycles  = 0;
        g            = 16'h0000;
        bus.in_valid = 1'b0;
        bus.in_bit   = 1'b0;
        clear_counts = 1'b0;
        reset        = 1'b1;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check_reset_values("por");
        reset = 1'b0;

        // Clean lock on seed 0x0005; first prediction is fb(0x0005) = 1
        load_seed(16'h0005, "seed5");
        g = {g[14:0], 1'b1};
        send(1'b1);
        check("first_pred_err", err_count, 16'd0);
        check("first_pred_bits", bit_count, 16'd1);

        wr_pulses = 0;
        repeat (999) gen_step(1'b0);
        check("clean1000_err", err_count, 16'd0);
        check("clean1000_bits", bit_count, 16'd1000);
        check("clean1000_locked", locked, 1'b1);
        check("clean1000_no_wr", wr_pulses, 0);

        // Align to a window boundary: 1000 = 15*64 + 40
        repeat (24) gen_step(1'b0);

        // Three errors per window keeps lock
        for (int w = 0; w < 3; w++) begin
            for (int i = 0; i < 64; i++) gen_step((i == 5) || (i == 30) || (i == 60));
            check("win3_locked", locked, 1'b1);
            check("win3_err", err_count, 32'(3 * (w + 1)));
        end
        check("win3_no_wr", wr_pulses, 0);

        // clear_counts on a mismatching bit wins over the increment
        clear_counts = 1'b1;
        gen_step(1'b1);
        clear_counts = 1'b0;
        check("clear_err", err_count, 16'd0);
        check("clear_bits", bit_count, 16'd0);
        repeat (63) gen_step(1'b0);
        check("clear_win_locked", locked, 1'b1);
        check("clear_win_bits", bit_count, 16'd63);

        // Four errors inside one window: report
        for (int i = 0; i < 31; i++) gen_step((i == 2) || (i == 10) || (i == 20) || (i == 30));
        check("rpt_wr_en", bus.mem_wr_en, 1'b1);
        check("rpt_address", bus.mem_address, 16'h07FD);
        check("rpt_data", bus.mem_data, 16'd4);
        check("rpt_locked", locked, 1'b0);
        check("rpt_err", err_count, 16'd4);
        check("rpt_bits", bit_count, 16'd94);

        // A valid bit offered during REPORT must be ignored
        send(1'b1);
        check("post_rpt_wr_en", bus.mem_wr_en, 1'b0);
        check("post_rpt_data_hold", bus.mem_data, 16'd4);
        check("post_rpt_locked", locked, 1'b0);

        // Relock on the continuing generator stream after 16 bits
        repeat (15) gen_step(1'b0);
        check("relock_at_15", locked, 1'b0);
        gen_step(1'b0);
        check("relock_at_16", locked, 1'b1);
        gen_step(1'b0);
        check("relock_err", err_count, 16'd4);
        check("relock_bits", bit_count, 16'd95);
        check("one_wr_pulse", wr_pulses, 1);

        // Reset asserted together with LOAD bit 10
        do_reset();
        g = 16'h0005;
        for (int i = 15; i >= 7; i--) send(g[i]);
        bus.in_valid = 1'b1;
        bus.in_bit   = g[6];
        reset        = 1'b1;
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
        check_reset_values("rst_load");
        reset = 1'b0;
        load_seed(16'h0005, "refill");
        gen_step(1'b0);
        check("refill_err", err_count, 16'd0);
        check("refill_bits", bit_count, 16'd1);

        // Reset during REPORT drops the write
        for (int i = 0; i < 4; i++) gen_step(1'b1);
        check("rpt2_wr_en", bus.mem_wr_en, 1'b1);
        check("rpt2_data", bus.mem_data, 16'd4);
        wr_pulses = 0;
        reset = 1'b1;
        #1;
        check_reset_values("rst_rpt");
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_rpt_no_wr", wr_pulses, 0);

        // All-ones stream never locks and never reports
        lock_cycles = 0;
        wr_pulses   = 0;
        repeat (64) send(1'b1);
        repeat (2) @(posedge clock);
        #1;
        check("ones_no_lock", lock_cycles, 0);
        check("ones_no_wr", wr_pulses, 0);
        check("ones_locked", locked, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
